// File: rtl/spc7110_rom_arbiter.sv
// SRAM0 access arbiter for the SPC7110 mapper: MCU, decompression unit and direct
// data port share the ROM bus in the gaps left by the SNES (SNES_BUSY).
module spc7110_rom_arbiter #(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SNES_BUSY,
  input  logic        MCU_REQ,
  input  logic        MCU_WE,
  input  logic [23:0] MCU_ADDR,
  input  logic [7:0]  MCU_WRDATA,
  output logic        MCU_ACK,
  input  logic        DCU_REQ,
  input  logic [23:0] DCU_ADDR,
  output logic        DCU_ACK,
  input  logic        DIR_REQ,
  input  logic [23:0] DIR_ADDR,
  output logic        DIR_ACK,
  input  logic [7:0]  ROM_DATA,
  output logic [7:0]  RDDATA,
  output logic [23:0] ROM_ADDR,
  output logic        ROM_OE,
  output logic        ROM_WE,
  output logic [7:0]  ROM_WRDATA,
  output logic        ARB_ACTIVE,
  output logic [1:0]  state_dbg
);

  // Handshake: each *_REQ is a level held by the requester; the matching *_ACK is a
  // single-cycle pulse after the access completes. Address/WE/data are taken at grant.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SRC_MCU = 2'd0, SRC_DCU = 2'd1, SRC_DIR = 2'd2} src_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  src_t        cur_src;
  src_t        retry_src;
  src_t        grant_src;
  logic [3:0]  cnt;
  logic        retry_valid;
  logic        rr_dir;
  logic        lat_we;
  logic        grant_valid;
  logic        sel_we;
  logic [23:0] sel_addr;
  logic [7:0]  sel_data;

  assign state_dbg = state;

  // A pending retry re-uses the already latched address/WE/data.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_MCU;
    sel_addr    = ROM_ADDR;
    sel_we      = lat_we;
    sel_data    = ROM_WRDATA;
    if (retry_valid) begin
      grant_valid = 1'b1;
      grant_src   = retry_src;
    end else if (MCU_REQ) begin
      grant_valid = 1'b1;
      grant_src   = SRC_MCU;
      sel_addr    = MCU_ADDR;
      sel_we      = MCU_WE;
      sel_data    = MCU_WRDATA;
    end else if (DCU_REQ && (!DIR_REQ || !rr_dir)) begin
      grant_valid = 1'b1;
      grant_src   = SRC_DCU;
      sel_addr    = DCU_ADDR;
      sel_we      = 1'b0;
    end else if (DIR_REQ) begin
      grant_valid = 1'b1;
      grant_src   = SRC_DIR;
      sel_addr    = DIR_ADDR;
      sel_we      = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cur_src     <= SRC_MCU;
      retry_src   <= SRC_MCU;
      cnt         <= 4'd0;
      retry_valid <= 1'b0;
      rr_dir      <= 1'b0;
      lat_we      <= 1'b0;
      MCU_ACK     <= 1'b0;
      DCU_ACK     <= 1'b0;
      DIR_ACK     <= 1'b0;
      RDDATA      <= 8'h00;
      ROM_ADDR    <= 24'h000000;
      ROM_OE      <= 1'b0;
      ROM_WE      <= 1'b0;
      ROM_WRDATA  <= 8'h00;
      ARB_ACTIVE  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!SNES_BUSY && grant_valid) begin
            state      <= ACCESS;
            cnt        <= CNT_LOAD;
            cur_src    <= grant_src;
            ROM_ADDR   <= sel_addr;
            lat_we     <= sel_we;
            ROM_WRDATA <= sel_data;
            ROM_OE     <= !sel_we;
            ROM_WE     <= sel_we;
            ARB_ACTIVE <= 1'b1;
          end
        end
        ACCESS: begin
          if (SNES_BUSY) begin
            // SNES reclaimed the bus: abandon and remember who to finish first.
            state       <= IDLE;
            ROM_OE      <= 1'b0;
            ROM_WE      <= 1'b0;
            ARB_ACTIVE  <= 1'b0;
            retry_valid <= 1'b1;
            retry_src   <= cur_src;
          end else if (cnt == 4'd0) begin
            state      <= DONE;
            ROM_OE     <= 1'b0;
            ROM_WE     <= 1'b0;
            ARB_ACTIVE <= 1'b0;
            if (!lat_we) RDDATA <= ROM_DATA;
            MCU_ACK <= (cur_src == SRC_MCU);
            DCU_ACK <= (cur_src == SRC_DCU);
            DIR_ACK <= (cur_src == SRC_DIR);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state       <= IDLE;
          MCU_ACK     <= 1'b0;
          DCU_ACK     <= 1'b0;
          DIR_ACK     <= 1'b0;
          retry_valid <= 1'b0;
          if (cur_src == SRC_DCU) rr_dir <= 1'b1;
          if (cur_src == SRC_DIR) rr_dir <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spc7110_rom_arbiter.sv
// Bench for spc7110_rom_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model of grant order, timing and read data.
module tb_spc7110_rom_arbiter;

  localparam int AC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        snes_busy;
  logic        mcu_req, mcu_we, mcu_ack;
  logic [23:0] mcu_addr;
  logic [7:0]  mcu_wrdata;
  logic        dcu_req, dcu_ack;
  logic [23:0] dcu_addr;
  logic        dir_req, dir_ack;
  logic [23:0] dir_addr;
  logic [7:0]  rom_data, rddata, rom_wrdata;
  logic [23:0] rom_addr;
  logic        rom_oe, rom_we, arb_active;
  logic [1:0]  state_dbg;

  logic        rom_ovr_en;
  logic [7:0]  rom_ovr;
  logic        rand_en;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  spc7110_rom_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .CLK(clk), .RST(rst), .SNES_BUSY(snes_busy),
    .MCU_REQ(mcu_req), .MCU_WE(mcu_we), .MCU_ADDR(mcu_addr), .MCU_WRDATA(mcu_wrdata),
    .MCU_ACK(mcu_ack),
    .DCU_REQ(dcu_req), .DCU_ADDR(dcu_addr), .DCU_ACK(dcu_ack),
    .DIR_REQ(dir_req), .DIR_ADDR(dir_addr), .DIR_ACK(dir_ack),
    .ROM_DATA(rom_data), .RDDATA(rddata), .ROM_ADDR(rom_addr), .ROM_OE(rom_oe),
    .ROM_WE(rom_we), .ROM_WRDATA(rom_wrdata), .ARB_ACTIVE(arb_active),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  assign rom_data = rom_ovr_en ? rom_ovr : rom_byte(rom_addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] cyc;
    logic [7:0]  data;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- reference model ----------------
  logic        m_inflight, m_retry, m_rr_dir, m_we;
  logic [1:0]  m_src, m_rsrc;
  logic [23:0] m_addr;
  logic [7:0]  m_wdata, m_last_rd, m_d;
  int          m_g, m_next_free;
  logic        m_act;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_outputs", 32'({arb_active, rom_oe, rom_we, mcu_ack, dcu_ack, dir_ack}), 32'd0);
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_rddata", 32'({rddata, rom_wrdata}), 32'd0);
      m_inflight = 1'b0; m_retry = 1'b0; m_rr_dir = 1'b0; m_we = 1'b0;
      m_src = 2'd0; m_rsrc = 2'd0; m_addr = 24'h0; m_wdata = 8'h0; m_last_rd = 8'h0;
      m_g = 0; m_next_free = cyc + 1;
    end else begin
      m_act = m_inflight && (cyc >= m_g + 1) && (cyc <= m_g + AC);
      check("arb_active", 32'(arb_active), 32'(m_act));
      check("rom_oe", 32'(rom_oe), 32'(m_act && !m_we));
      check("rom_we", 32'(rom_we), 32'(m_act && m_we));
      check("rom_addr", 32'(rom_addr), 32'(m_addr));
      check("rom_wrdata", 32'(rom_wrdata), 32'(m_wdata));
      if (m_inflight) begin
        if (snes_busy) begin
          m_inflight  = 1'b0;
          m_retry     = 1'b1;
          m_rsrc      = m_src;
          m_next_free = cyc + 1;
        end else if (cyc == m_g + AC) begin
          m_d = m_we ? m_last_rd : (rom_ovr_en ? rom_ovr : rom_byte(m_addr));
          m_last_rd = m_d;
          exp_q.push_back('{src: m_src, cyc: 32'(cyc + 1), data: m_d});
          m_inflight  = 1'b0;
          m_retry     = 1'b0;
          m_next_free = cyc + 2;
          if (m_src == 2'd1) m_rr_dir = 1'b1;
          if (m_src == 2'd2) m_rr_dir = 1'b0;
        end
      end else if (cyc >= m_next_free && !snes_busy) begin
        m_inflight = 1'b1;
        if (m_retry) begin
          m_src = m_rsrc;
        end else if (mcu_req) begin
          m_src = 2'd0; m_addr = mcu_addr; m_we = mcu_we; m_wdata = mcu_wrdata;
        end else if (dcu_req && (!dir_req || !m_rr_dir)) begin
          m_src = 2'd1; m_addr = dcu_addr; m_we = 1'b0;
        end else if (dir_req) begin
          m_src = 2'd2; m_addr = dir_addr; m_we = 1'b0;
        end else begin
          m_inflight = 1'b0;
        end
        if (m_inflight) m_g = cyc;
      end
    end
  end

  // ---------------- monitor ----------------
  exp_t e;
  logic [1:0] ack_src;
  always @(negedge clk) begin
    if (!rst) begin
      if (32'(mcu_ack) + 32'(dcu_ack) + 32'(dir_ack) > 32'd1) begin
        check("one_hot_ack", 32'({mcu_ack, dcu_ack, dir_ack}), 32'd0);
      end else if (mcu_ack || dcu_ack || dir_ack) begin
        ack_src = mcu_ack ? 2'd0 : (dcu_ack ? 2'd1 : 2'd2);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(ack_src), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("ack_src", 32'(ack_src), 32'(e.src));
          check("ack_cycle", 32'(cyc), e.cyc);
          check("rddata", 32'(rddata), 32'(e.data));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= 32'(cyc)) begin
        e = exp_q.pop_front();
        check("missing_ack", 32'(cyc), e.cyc + 32'd1000);
      end
    end
  end

  // ---------------- drivers ----------------
  // Requesters drop their level as soon as they see their ACK; random mode re-raises.
  always @(posedge clk) begin
    #1;
    if (mcu_req && mcu_ack) mcu_req = 1'b0;
    else if (rand_en && !mcu_req && $urandom_range(0, 2) == 0) begin
      mcu_we = 1'($urandom_range(0, 1)); mcu_addr = 24'($urandom);
      mcu_wrdata = 8'($urandom); mcu_req = 1'b1;
    end
    if (dcu_req && dcu_ack) dcu_req = 1'b0;
    else if (rand_en && !dcu_req && $urandom_range(0, 2) == 0) begin
      dcu_addr = 24'($urandom); dcu_req = 1'b1;
    end
    if (dir_req && dir_ack) dir_req = 1'b0;
    else if (rand_en && !dir_req && $urandom_range(0, 2) == 0) begin
      dir_addr = 24'($urandom); dir_req = 1'b1;
    end
    if (rand_en) snes_busy = ($urandom_range(0, 19) == 0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic req_of(input int which);
    return (which == 0) ? mcu_req : ((which == 1) ? dcu_req : dir_req);
  endfunction

  task automatic wait_drop(input int which);
    int n;
    n = 0;
    while (req_of(which) && n < 300) begin
      tick();
      n++;
    end
    check("req_served", 32'(req_of(which)), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; snes_busy = 1'b0; rand_en = 1'b0;
    mcu_req = 1'b0; mcu_we = 1'b0; mcu_addr = 24'h0; mcu_wrdata = 8'h0;
    dcu_req = 1'b0; dcu_addr = 24'h0; dir_req = 1'b0; dir_addr = 24'h0;
    rom_ovr_en = 1'b0; rom_ovr = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) tick();

    // DCU read with a fixed ROM byte
    rom_ovr_en = 1'b1; rom_ovr = 8'h5A;
    dcu_addr = 24'hD01234; dcu_req = 1'b1;
    wait_drop(1);
    tick();
    check("dcu_read_rddata", 32'(rddata), 32'h5A);
    rom_ovr_en = 1'b0;

    // MCU write leaves RDDATA alone
    mcu_we = 1'b1; mcu_addr = 24'hE00010; mcu_wrdata = 8'hA5; mcu_req = 1'b1;
    wait_drop(0);
    tick();
    check("mcu_write_rddata", 32'(rddata), 32'h5A);
    mcu_we = 1'b0;

    // all three requesting together
    repeat (2) tick();
    mcu_addr = 24'($urandom); dcu_addr = 24'($urandom); dir_addr = 24'($urandom);
    mcu_req = 1'b1; dcu_req = 1'b1; dir_req = 1'b1;
    wait_drop(0); wait_drop(1); wait_drop(2);
    dcu_req = 1'b1; dir_req = 1'b1;
    wait_drop(1); wait_drop(2);

    // DIR read aborted in its third access cycle, retried ahead of a new MCU request
    repeat (3) tick();
    dir_addr = 24'($urandom); dir_req = 1'b1;
    repeat (3) tick();
    snes_busy = 1'b1;
    mcu_we = 1'b0; mcu_addr = 24'($urandom); mcu_req = 1'b1;
    tick();
    snes_busy = 1'b0;
    wait_drop(2);
    check("mcu_waits_for_retry", 32'(mcu_req), 32'd1);
    wait_drop(0);

    // reset during a DCU read
    repeat (3) tick();
    dcu_addr = 24'($urandom); dcu_req = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("async_rst_oe", 32'({rom_oe, arb_active}), 32'd0);
    tick();
    rst = 1'b0;
    wait_drop(1);

    // random traffic with SNES bus interference
    rand_en = 1'b1;
    repeat (3000) tick();
    rand_en = 1'b0;
    snes_busy = 1'b0;
    wait_drop(0); wait_drop(1); wait_drop(2);
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
